multiplier_unit: RTL and testbench

- Parameterized N-bit unsigned integer multiplier: A x B -> 2N-bit product Sum.
- Iterative radix-2 shift-and-add: one multiplier bit per clock.
- Start/busy/done handshake for use as a shared arithmetic resource in the DSP datapath.

---
 rtl/multiplier_unit.sv | 115 +++++++++++
 tb/tb_multiplier_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multiplier_unit.sv
// Iterative radix-2 shift-and-add unsigned multiplier, N x N -> 2N bits.
// Optional `MULTIPLIER_EARLY_DONE_EN: finish as soon as the remaining multiplier bits are zero.
module multiplier_unit #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] Sum,
    output logic           busy,
    output logic           done,
    output logic           o_dbg_state
);

    // Handshake: start is accepted on any rising edge where busy=0 (including the done
    // cycle); busy stays high until the completing edge, after which done pulses for one
    // cycle with the new Sum. start while busy is dropped, never queued.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [2*N-1:0] r_mcand;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_sum;
    logic [N-1:0]   r_mplr;
    logic           r_done;
    logic [2*N-1:0] w_addend;
    logic [2*N-1:0] w_acc_next;
    logic           w_last;

    assign w_addend   = r_mplr[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

`ifdef MULTIPLIER_EARLY_DONE_EN
    assign w_last = (r_mplr[N-1:1] == '0);
`else
    localparam int CW = $clog2(N + 1);
    logic [CW-1:0] r_cnt;

    assign w_last = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_cnt <= CW'(N);
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next_state = ST_RUN;
            ST_RUN:  if (w_last) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state == ST_RUN);
        done        = r_done;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand <= {{N{1'b0}}, A};
                        r_mplr  <= B;
                        r_acc   <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    // Sum is only ever written with a finished product
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum = r_sum;

endmodule

// File: tb/tb_multiplier_unit.sv
// Directed bench for multiplier_unit (N=4): exhaustive products, latency, handshake corners.
module tb_multiplier_unit;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] Sum;
    logic           busy;
    logic           done;
    logic           o_dbg_state;

    int n_checks;
    int n_fail;

    multiplier_unit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Sum(Sum), .busy(busy), .done(done), .o_dbg_state(o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int exp_lat(input logic [N-1:0] b);
`ifdef MULTIPLIER_EARLY_DONE_EN
        int hi;
        hi = 1;
        for (int i = 0; i < N; i++) if (b[i]) hi = i + 1;
        return hi;
`else
        return N;
`endif
    endfunction

    // Present a start with operands; returns just after the accepting edge.
    task automatic launch(input int a, input int b);
        start = 1'b1;
        A     = N'(a);
        B     = N'(b);
        step();
        start = 1'b0;
    endtask

    // Count edges until done; optionally scramble operands or check Sum is held meanwhile.
    task automatic wait_done(input bit scramble, input bit hold_en, input int hold_val,
                             output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            if (hold_en) check("sum_hold_mid_op", int'(Sum), hold_val);
            check("busy_during_run", int'(busy), 1);
            if (scramble) begin
                A = N'(lat * 5 + 3);
                B = N'(lat * 7 + 1);
            end
            step();
            lat++;
        end
        check("done_seen", int'(done), 1);
        check("busy_low_at_done", int'(busy), 0);
    endtask

    task automatic run_op(input string tag, input int a, input int b);
        int lat;
        launch(a, b);
        wait_done(1'b0, 1'b0, 0, lat);
        check({tag, "_sum"}, int'(Sum), a * b);
        check({tag, "_lat"}, lat, exp_lat(N'(b)));
    endtask

    initial begin
        int lat;
        int done_cnt;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;

        // Reset state
        step();
        step();
        check("rst_sum", int'(Sum), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_state", int'(o_dbg_state), 0);
        rst = 1'b0;
        step();

        // Max case, exact latency
        run_op("max_15x15", 15, 15);
        check("max_sum_225", int'(Sum), 225);
        step();
        check("done_one_cycle", int'(done), 0);
        step();
        step();
        check("sum_held_idle", int'(Sum), 225);
        run_op("a7_b1", 7, 1);

        // Exhaustive products
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op("exh", a, b);
            end
        end

        // start while busy is ignored
        launch(3, 5);
        start = 1'b1;
        A     = 4'd9;
        B     = 4'd9;
        step();
        start = 1'b0;
        wait_done(1'b0, 1'b0, 0, lat);
        check("busy_start_sum", int'(Sum), 15);
        check("busy_start_lat", lat + 1, exp_lat(4'd5));
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("busy_start_no_2nd_done", done_cnt, 0);
        check("busy_start_idle", int'(busy), 0);
        check("busy_start_sum_held", int'(Sum), 15);

        // Reset mid-operation
        launch(12, 11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_sum", int'(Sum), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) done_cnt++;
        end
        check("midrst_quiet", done_cnt, 0);
        run_op("after_rst_2x3", 2, 3);

        // Back-to-back: second start issued in the done cycle
        launch(6, 7);
        wait_done(1'b0, 1'b0, 0, lat);
        check("b2b_first_sum", int'(Sum), 42);
        launch(5, 5);
        check("b2b_second_busy", int'(busy), 1);
        check("b2b_done_cleared", int'(done), 0);
        wait_done(1'b0, 1'b1, 42, lat);
        check("b2b_second_sum", int'(Sum), 25);
        check("b2b_second_lat", lat, exp_lat(4'd5));

        // Operand changes during RUN
        launch(10, 13);
        wait_done(1'b1, 1'b1, 25, lat);
        check("scramble_sum", int'(Sum), 130);
        check("scramble_lat", lat, exp_lat(4'd13));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
